core_run_sequencer: RTL

CORE_RUN_SEQUENCER -- requirements
Module: core_run_sequencer

---
 rtl/core_run_pkg.sv | 18 +
 rtl/run_cycle_counter.sv | 36 +++
 rtl/core_run_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/core_run_pkg.sv
// Shared types and default parameter values for the core run sequencer.
package core_run_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAssert,
    StRelease,
    StRun,
    StDone
  } run_state_e;

  localparam int unsigned DefNumCh     = 2;
  localparam int unsigned DefRstCycles = 1;
  localparam int unsigned DefStagger   = 1;
  localparam int unsigned DefMaxCycles = 20;
  localparam int unsigned DefCntW      = 16;

endpackage

// File: rtl/run_cycle_counter.sv
// RUN-phase cycle counter with synchronous clear, enable and a terminal-value flag.
module run_cycle_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] count_o,
  output logic             term_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = (count_q == term_i);

endmodule

// File: rtl/core_run_sequencer.sv
// Sequences staggered core reset release, supervises the run and reports how it ended.
module core_run_sequencer
  import core_run_pkg::*;
#(
  parameter int unsigned NUM_CH     = DefNumCh,
  parameter int unsigned RST_CYCLES = DefRstCycles,
  parameter int unsigned STAGGER    = DefStagger,
  parameter int unsigned MAX_CYCLES = DefMaxCycles,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [NUM_CH-1:0] halt_i,
  output logic [NUM_CH-1:0] ch_reset_n_o,
  output logic              running_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic              aborted_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  // Edge index (relative to the start edge) at which the last channel is released.
  localparam int unsigned LastRel = RST_CYCLES + (NUM_CH - 1) * STAGGER;
  localparam int unsigned TickW   = $clog2(LastRel + 2);
  localparam logic [CNT_W-1:0] TermVal = CNT_W'(MAX_CYCLES - 1);

  run_state_e state_q, state_d;

  logic [NUM_CH-1:0] ch_rst_n_q, ch_rst_n_d;
  logic [NUM_CH-1:0] halt_flags_q, halt_flags_d;
  logic [NUM_CH-1:0] halt_upd;
  logic [NUM_CH-1:0] rel_mask;
  logic [TickW-1:0]  tick_q, tick_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              aborted_q, aborted_d;
  logic              cnt_clr, cnt_en, cnt_term;

  run_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .term_i  (TermVal),
    .count_o (cycle_cnt_o),
    .term_o  (cnt_term)
  );

  // tick_q holds the index of the upcoming edge; channel k is out of reset from its threshold on.
  always_comb begin
    rel_mask = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      rel_mask[k] = (32'(tick_q) >= (RST_CYCLES + k * STAGGER));
    end
  end

  // Only channels already out of reset during this cycle may report a halt.
  assign halt_upd = halt_flags_q | (halt_i & ch_rst_n_q);

  always_comb begin
    state_d      = state_q;
    ch_rst_n_d   = ch_rst_n_q;
    halt_flags_d = halt_flags_q;
    tick_d       = tick_q;
    running_d    = running_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    aborted_d    = aborted_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d      = StAssert;
          ch_rst_n_d   = '0;
          halt_flags_d = '0;
          tick_d       = TickW'(1);
          running_d    = 1'b0;
          done_d       = 1'b0;
          timeout_d    = 1'b0;
          aborted_d    = 1'b0;
          cnt_clr      = 1'b1;
        end
      end
      StAssert, StRelease: begin
        if (abort_i) begin
          state_d    = StDone;
          ch_rst_n_d = '0;
          running_d  = 1'b0;
          done_d     = 1'b1;
          timeout_d  = 1'b0;
          aborted_d  = 1'b1;
        end else begin
          halt_flags_d = halt_upd;
          ch_rst_n_d   = rel_mask;
          if (tick_q != TickW'(LastRel)) begin
            tick_d = tick_q + 1'b1;
          end
          if (&rel_mask) begin
            state_d   = StRun;
            running_d = 1'b1;
          end else if (rel_mask[0]) begin
            state_d = StRelease;
          end
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d    = StDone;
          ch_rst_n_d = '0;
          running_d  = 1'b0;
          done_d     = 1'b1;
          timeout_d  = 1'b0;
          aborted_d  = 1'b1;
        end else begin
          halt_flags_d = halt_upd;
          if (&halt_upd) begin
            state_d   = StDone;
            running_d = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b0;
          end else if (cnt_term) begin
            state_d   = StDone;
            running_d = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      ch_rst_n_q   <= '1;
      halt_flags_q <= '0;
      tick_q       <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_rst_n_q   <= ch_rst_n_d;
      halt_flags_q <= halt_flags_d;
      tick_q       <= tick_d;
      running_q    <= running_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      aborted_q    <= aborted_d;
    end
  end

  assign ch_reset_n_o = ch_rst_n_q;
  assign running_o    = running_q;
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;
  assign aborted_o    = aborted_q;

endmodule
